// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line responder: receives 48-bit host commands, checks CRC7
// and framing, then serialises a short or long response after the NCR gap.
module sd_cmd_responder #(
  parameter int NCR         = 2,
  parameter int RSP_TIMEOUT = 64
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         bit_en_i,
  input  logic         sd_cmd_dat_i,
  output logic         sd_cmd_out_o,
  output logic         sd_cmd_oe_o,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_err_o,
  input  logic         rsp_valid_i,
  output logic         rsp_ready_o,
  input  logic         rsp_long_i,
  input  logic [127:0] rsp_data_i,
  output logic         busy_o
);

  // Response handshake: a response transfers on any wb_clk_i cycle where
  // rsp_valid_i and rsp_ready_o are both high; rsp_ready_o is high only while
  // waiting with no response latched, and rsp_valid_i may rise at any time.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RX    = 3'd1,
    S_CHECK = 3'd2,
    S_WAIT  = 3'd3,
    S_TX    = 3'd4
  } state_t;

  localparam logic [7:0] NCR_C     = 8'(NCR);
  localparam logic [7:0] TIMEOUT_C = 8'(RSP_TIMEOUT);

  state_t         state_q, state_d;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic [6:0]     wait_cnt_q, wait_cnt_d;
  logic [47:0]    rx_sh_q, rx_sh_d;
  logic [6:0]     crc_q, crc_d;
  logic [127:0]   tx_sh_q, tx_sh_d;
  logic           long_q, long_d;
  logic           have_rsp_q, have_rsp_d;
  logic           out_q, out_d;
  logic           oe_q, oe_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [5:0]     index_q, index_d;
  logic [31:0]    arg_q, arg_d;

  logic           good;
  logic           emit;
  logic           start_ok;
  logic [7:0]     wait_inc;
  logic [7:0]     data_len;
  logic [7:0]     tx_pos;
  logic           crc_in_tx;
  logic           unused_rsp_bits;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  assign good      = rx_sh_q[46] && rx_sh_q[0] && (rx_sh_q[7:1] == crc_q);
  assign wait_inc  = {1'b0, wait_cnt_q} + 8'd1;
  assign start_ok  = have_rsp_q && (wait_inc >= NCR_C);
  assign data_len  = long_q ? 8'd128 : 8'd40;
  assign tx_pos    = (state_q == S_WAIT) ? 8'd0 : bit_cnt_q;
  // Long responses exclude the leading 0,0,111111 header from the CRC.
  assign crc_in_tx = long_q ? (tx_pos >= 8'd8) : 1'b1;
  assign unused_rsp_bits = ^rsp_data_i[7:0];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rx_sh_d    = rx_sh_q;
    crc_d      = crc_q;
    tx_sh_d    = tx_sh_q;
    long_d     = long_q;
    have_rsp_d = have_rsp_q;
    out_d      = out_q;
    oe_d       = oe_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    index_d    = index_q;
    arg_d      = arg_q;
    emit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        oe_d  = 1'b0;
        out_d = 1'b1;
        if (bit_en_i && !sd_cmd_dat_i) begin
          state_d   = S_RX;
          bit_cnt_d = 8'd1;
          rx_sh_d   = 48'd0;
          crc_d     = 7'd0;
        end
      end

      S_RX: begin
        if (bit_en_i) begin
          rx_sh_d = {rx_sh_q[46:0], sd_cmd_dat_i};
          if (bit_cnt_q < 8'd40) crc_d = crc7_step(crc_q, sd_cmd_dat_i);
          bit_cnt_d = bit_cnt_q + 8'd1;
          if (bit_cnt_q == 8'd47) state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        bit_cnt_d  = 8'd0;
        wait_cnt_d = 7'd0;
        crc_d      = 7'd0;
        have_rsp_d = 1'b0;
        if (good) begin
          valid_d = 1'b1;
          index_d = rx_sh_q[45:40];
          arg_d   = rx_sh_q[39:8];
          state_d = S_WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (rsp_valid_i && !have_rsp_q) begin
          have_rsp_d = 1'b1;
          long_d     = rsp_long_i;
          tx_sh_d    = rsp_long_i ? {8'b0011_1111, rsp_data_i[127:8]}
                                  : {2'b00, rsp_data_i[37:0], 88'd0};
        end
        if (bit_en_i) begin
          wait_cnt_d = wait_inc[6:0];
          if (start_ok) begin
            state_d = S_TX;
            emit    = 1'b1;
          end else if (!have_rsp_q && !rsp_valid_i && (wait_inc >= TIMEOUT_C)) begin
            state_d = S_IDLE;
          end
        end
      end

      S_TX: begin
        if (bit_en_i) emit = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // Frame layout: data bits (header included), 7 CRC bits, end bit, release.
    if (emit) begin
      oe_d      = 1'b1;
      bit_cnt_d = tx_pos + 8'd1;
      if (tx_pos < data_len) begin
        out_d   = tx_sh_q[127];
        tx_sh_d = {tx_sh_q[126:0], 1'b0};
        if (crc_in_tx) crc_d = crc7_step(crc_q, tx_sh_q[127]);
      end else if (tx_pos < data_len + 8'd7) begin
        out_d = crc_q[6];
        crc_d = {crc_q[5:0], 1'b0};
      end else if (tx_pos == data_len + 8'd7) begin
        out_d = 1'b1;
      end else begin
        oe_d    = 1'b0;
        out_d   = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 8'd0;
      wait_cnt_q <= 7'd0;
      rx_sh_q    <= 48'd0;
      crc_q      <= 7'd0;
      tx_sh_q    <= 128'd0;
      long_q     <= 1'b0;
      have_rsp_q <= 1'b0;
      out_q      <= 1'b1;
      oe_q       <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      index_q    <= 6'd0;
      arg_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rx_sh_q    <= rx_sh_d;
      crc_q      <= crc_d;
      tx_sh_q    <= tx_sh_d;
      long_q     <= long_d;
      have_rsp_q <= have_rsp_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      index_q    <= index_d;
      arg_q      <= arg_d;
    end
  end

  assign sd_cmd_out_o = out_q;
  assign sd_cmd_oe_o  = oe_q;
  assign cmd_valid_o  = valid_q;
  assign cmd_err_o    = err_q;
  assign cmd_index_o  = index_q;
  assign cmd_arg_o    = arg_q;
  assign rsp_ready_o  = (state_q == S_WAIT) && !have_rsp_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: a line-level model builds expected
// response frames and command records, and one monitor compares every cycle.
module tb_sd_cmd_responder;
  localparam int NCR         = 2;
  localparam int RSP_TIMEOUT = 64;

  logic         clk;
  logic         rst;
  logic         bit_en;
  logic         cmd_dat;
  logic         cmd_out;
  logic         cmd_oe;
  logic         cmd_valid;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         cmd_err;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_long;
  logic [127:0] rsp_data;
  logic         busy;

  sd_cmd_responder #(.NCR(NCR), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .bit_en_i     (bit_en),
    .sd_cmd_dat_i (cmd_dat),
    .sd_cmd_out_o (cmd_out),
    .sd_cmd_oe_o  (cmd_oe),
    .cmd_valid_o  (cmd_valid),
    .cmd_index_o  (cmd_index),
    .cmd_arg_o    (cmd_arg),
    .cmd_err_o    (cmd_err),
    .rsp_valid_i  (rsp_valid),
    .rsp_ready_o  (rsp_ready),
    .rsp_long_i   (rsp_long),
    .rsp_data_i   (rsp_data),
    .busy_o       (busy)
  );

  // ---------------- clock / reset / bit strobe ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bit_en = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bit_en = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_valid  = 0;
  int          n_err    = 0;
  int          n_oe_bits = 0;
  logic [1:0]  exp_q[$];       // expected {oe,out} per bit period
  logic [37:0] exp_cmd_q[$];   // expected {index,arg} per good command
  logic [1:0]  prev_line;
  logic [1:0]  line_exp;
  logic [37:0] cmd_exp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [6:0] crc7(input logic [127:0] v, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = v[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_token(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] b;
    b = {2'b01, idx, arg};
    return {b, crc7({88'd0, b}, 40), 1'b1};
  endfunction

  task automatic push_frame(input logic lng, input logic [127:0] data);
    logic [135:0] f;
    logic [39:0]  b40;
    int           n;
    if (!lng) begin
      b40 = {2'b00, data[37:0]};
      f   = {88'd0, b40, crc7({88'd0, b40}, 40), 1'b1};
      n   = 48;
    end else begin
      f = {2'b00, 6'b111111, data[127:8], crc7({8'd0, data[127:8]}, 120), 1'b1};
      n = 136;
    end
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({1'b1, f[i]});
  endtask

  // ---------------- compare process ----------------
  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      prev_line = 2'b01;
    end else begin
      if (cmd_valid) begin
        n_valid++;
        if (exp_cmd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL cmd_valid: got unexpected pulse idx=%0h arg=%0h", cmd_index, cmd_arg);
        end else begin
          cmd_exp = exp_cmd_q.pop_front();
          check("cmd_index_arg", {cmd_index, cmd_arg}, cmd_exp);
        end
      end
      if (cmd_err) n_err++;
      if (bit_en) begin
        line_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b01;
        check("line_bit", {cmd_oe, cmd_out}, line_exp);
        if (cmd_oe) n_oe_bits++;
      end else begin
        check("line_stable", {cmd_oe, cmd_out}, prev_line);
      end
      prev_line = {cmd_oe, cmd_out};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bit_step();
    do @(posedge clk); while (!bit_en);
    @(negedge clk);
  endtask

  task automatic send_token(input logic [47:0] tok);
    for (int i = 47; i >= 0; i--) begin
      cmd_dat = tok[i];
      bit_step();
    end
    cmd_dat = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (!rsp_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_accept", rsp_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      bit_step();
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    bit_step();
    check("busy_after_tx", busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  int          v0, e0, oe0;
  logic        ready_seen;
  logic [47:0] bad_tok[3];
  logic [39:0] b40;

  initial begin
    rst = 1'b1; cmd_dat = 1'b1;
    rsp_valid = 1'b0; rsp_long = 1'b0; rsp_data = 128'd0;
    repeat (3) @(negedge clk);
    check("reset_line", {cmd_oe, cmd_out}, 2'b01);
    check("reset_pulses", {cmd_valid, cmd_err, rsp_ready, busy}, 4'b0000);
    check("reset_idx_arg", {cmd_index, cmd_arg}, 38'd0);
    rst = 1'b0;
    @(negedge clk);

    check("model_cmd0", make_token(6'd0, 32'd0), 48'h400000000095);
    check("model_cmd8", make_token(6'd8, 32'h1AA), 48'h48000001AA87);

    // CMD0, response withheld: silent timeout
    exp_cmd_q.push_back({6'd0, 32'd0});
    v0 = n_valid;
    send_token(make_token(6'd0, 32'd0));
    for (int k = 1; k <= RSP_TIMEOUT; k++) begin
      bit_step();
      if (k == 1) check("cmd0_ready_in_wait", rsp_ready, 1);
      if (k == RSP_TIMEOUT - 1) check("cmd0_busy_before_timeout", busy, 1);
    end
    check("cmd0_busy_at_timeout", busy, 0);
    check("cmd0_ready_at_timeout", rsp_ready, 0);
    check("cmd0_valid_count", n_valid - v0, 1);

    // CMD8 with R7 offered immediately
    exp_cmd_q.push_back({6'd8, 32'h1AA});
    rsp_long = 1'b0;
    rsp_data = {90'd0, 6'd8, 32'h1AA};
    rsp_valid = 1'b1;
    oe0 = n_oe_bits;
    send_token(make_token(6'd8, 32'h1AA));
    repeat (NCR - 1) exp_q.push_back(2'b01);
    push_frame(1'b0, rsp_data);
    wait_accept();
    bit_step();
    check("r7_oe_before_ncr", cmd_oe, 0);
    bit_step();
    check("r7_oe_at_ncr", cmd_oe, 1);
    drain();
    check("r7_bits_driven", n_oe_bits - oe0, 48);

    // bad CRC, bad transmission bit, bad end bit
    b40 = {2'b00, 6'd8, 32'h1AA};
    bad_tok[0] = 48'h48000001AA85;
    bad_tok[1] = {b40, crc7({88'd0, b40}, 40), 1'b1};
    bad_tok[2] = {make_token(6'd8, 32'h1AA)} & ~48'd1;
    for (int t = 0; t < 3; t++) begin
      e0 = n_err; v0 = n_valid; ready_seen = 1'b0;
      send_token(bad_tok[t]);
      repeat (8) begin
        @(negedge clk);
        if (rsp_ready) ready_seen = 1'b1;
      end
      check("bad_err_pulse", n_err - e0, 1);
      check("bad_no_valid", n_valid - v0, 0);
      check("bad_ready_low", ready_seen, 0);
      check("bad_idx_arg_kept", {cmd_index, cmd_arg}, {6'd8, 32'h1AA});
      check("bad_busy", busy, 0);
    end

    // CMD2 with R2
    exp_cmd_q.push_back({6'd2, 32'd0});
    rsp_long = 1'b1;
    rsp_data = {120'h0123456789ABCDEF0123456789ABCD, 8'h00};
    rsp_valid = 1'b1;
    oe0 = n_oe_bits;
    send_token(make_token(6'd2, 32'd0));
    repeat (NCR - 1) exp_q.push_back(2'b01);
    push_frame(1'b1, rsp_data);
    wait_accept();
    drain();
    check("r2_bits_driven", n_oe_bits - oe0, 136);

    // CMD55 with R1 offered 20 bit periods late
    exp_cmd_q.push_back({6'd55, 32'd0});
    send_token(make_token(6'd55, 32'd0));
    repeat (20) bit_step();
    check("late_oe_idle", cmd_oe, 0);
    check("late_ready", rsp_ready, 1);
    rsp_long = 1'b0;
    rsp_data = {90'd0, 6'd55, 32'h00000120};
    rsp_valid = 1'b1;
    push_frame(1'b0, rsp_data);
    wait_accept();
    bit_step();
    check("late_first_bit", {cmd_oe, cmd_out}, 2'b10);
    drain();

    // CMD2 + R2 interrupted by reset after 70 driven bits
    exp_cmd_q.push_back({6'd2, 32'd0});
    rsp_long = 1'b1;
    rsp_data = {120'h0123456789ABCDEF0123456789ABCD, 8'h00};
    rsp_valid = 1'b1;
    send_token(make_token(6'd2, 32'd0));
    repeat (NCR - 1) exp_q.push_back(2'b01);
    push_frame(1'b1, rsp_data);
    wait_accept();
    repeat (NCR - 1 + 70) bit_step();
    check("r2_mid_oe", cmd_oe, 1);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_line", {cmd_oe, cmd_out}, 2'b01);
    check("async_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // CMD0 after reset
    exp_cmd_q.push_back({6'd0, 32'd0});
    v0 = n_valid;
    send_token(make_token(6'd0, 32'd0));
    repeat (4) bit_step();
    check("post_rst_valid", n_valid - v0, 1);
    check("post_rst_idx_arg", {cmd_index, cmd_arg}, 38'd0);
    for (int k = 0; k < RSP_TIMEOUT + 4 && busy; k++) bit_step();
    check("post_rst_busy", busy, 0);
    check("cmd_queue_empty", exp_cmd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
